// File: rtl/module_spi_burst_ctrl.sv
// Burst SPI sequencer: for each word of a burst, reads the TX word from the
// register-file memory, launches one SPI transfer, waits for completion and
// writes the received word back to the same address.
module module_spi_burst_ctrl #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] base_addr_i,
  input  logic [N:0]   n_words_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] mem_addr_rs1_o,
  input  logic [W-1:0] mem_rs1_i,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_rd_o,
  output logic [W-1:0] mem_data_o,
  output logic         spi_start_o,
  output logic [W-1:0] spi_tx_o,
  input  logic         spi_done_i,
  input  logic [W-1:0] spi_rx_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [N:0]   idx_q, idx_d;
  logic [N:0]   idx_inc;
  logic [N-1:0] base_q, base_d;
  logic [N:0]   n_q, n_d;
  logic [W-1:0] tx_q, tx_d;
  logic [W-1:0] rx_q, rx_d;
  logic [N-1:0] addr_d;

  // Output registers; loaded from the next state so each output is valid
  // during the cycle its state is active.
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] rs1_addr_q, rs1_addr_d;
  logic         we_q, we_d;
  logic [N-1:0] rd_addr_q, rd_addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic         spi_start_q, spi_start_d;
  logic [W-1:0] spi_tx_q, spi_tx_d;

  assign idx_inc = idx_q + (N+1)'(1);

  // Next-state, burst bookkeeping and next-cycle output values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    n_d     = n_q;
    tx_d    = tx_q;
    rx_d    = rx_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d  = base_addr_i;
          n_d     = n_words_i;
          idx_d   = '0;
          state_d = (n_words_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        tx_d    = mem_rs1_i;
        state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done_i) begin
          rx_d    = spi_rx_i;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == n_q) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Word address wraps modulo the memory depth.
    addr_d      = base_d + idx_d[N-1:0];

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    rs1_addr_d  = (state_d == S_LOAD)  ? addr_d : '0;
    we_d        = (state_d == S_WRITE);
    rd_addr_d   = (state_d == S_WRITE) ? addr_d : '0;
    wdata_d     = (state_d == S_WRITE) ? rx_d   : '0;
    spi_start_d = (state_d == S_START);
    spi_tx_d    = ((state_d == S_START) || (state_d == S_WAIT)) ? tx_d : '0;
  end

  // State, bookkeeping and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      n_q         <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rs1_addr_q  <= '0;
      we_q        <= 1'b0;
      rd_addr_q   <= '0;
      wdata_q     <= '0;
      spi_start_q <= 1'b0;
      spi_tx_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      n_q         <= n_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rs1_addr_q  <= rs1_addr_d;
      we_q        <= we_d;
      rd_addr_q   <= rd_addr_d;
      wdata_q     <= wdata_d;
      spi_start_q <= spi_start_d;
      spi_tx_q    <= spi_tx_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mem_addr_rs1_o = rs1_addr_q;
  assign mem_we_o       = we_q;
  assign mem_addr_rd_o  = rd_addr_q;
  assign mem_data_o     = wdata_q;
  assign spi_start_o    = spi_start_q;
  assign spi_tx_o       = spi_tx_q;

endmodule
